// File: rtl/tx_shift_ctrl_pkg.sv
//==============================================================================
// Module : tx_pkg
// Brief  : Shared state encoding and defaults for the tx shift-register control.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  localparam int DEF_NUM_BITS     = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

endpackage

`default_nettype wire

// File: rtl/tx_shift_ctrl_if.sv
//==============================================================================
// Module : tx_shift_ctrl_if
// Brief  : Valid/ready word handshake plus abort between word source and control.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface tx_shift_ctrl_if
  import tx_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS
);

  logic [NUM_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                tx_abort;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_abort,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_abort,
    output tx_ready
  );

endinterface

`default_nettype wire

// File: rtl/tx_shift_ctrl_bit_timer.sv
//==============================================================================
// Module : tx_bit_timer
// Brief  : Bit-period counter; bit_tick on the last clock of each bit period.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tx_bit_timer
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int                c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign bit_tick  = w_at_last && !clear;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt <= '0;
    end else if (clear || w_at_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_shift_ctrl.sv
//==============================================================================
// Module : tx_shift_ctrl
// Brief  : Drives load/shift/clear of the tx shift register, one bit per
//          CLKS_PER_BIT clocks, MSB first. Optional macro TX_PARITY_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tx_shift_ctrl
  import tx_pkg::*;
#(
  parameter int NUM_BITS     = DEF_NUM_BITS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                clk,
  input  logic                n_rst,
  tx_shift_ctrl_if.slave      tx_bus,
  output logic                load_enable,
  output logic [NUM_BITS-1:0] parallel_in,
  output logic                shift_enable,
  output logic                serial_in,
  output logic                s_reset,
  output logic                tx_active,
  output logic                word_done
);

`ifdef TX_PARITY_EN
  localparam int c_WORD_BITS = NUM_BITS + 1;
`else
  localparam int c_WORD_BITS = NUM_BITS;
`endif
  localparam int                 c_CNT_W    = $clog2(c_WORD_BITS);
  localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(c_WORD_BITS - 1);

  tx_state_t          r_state;
  tx_state_t          w_next_state;
  logic [c_CNT_W-1:0] r_bit_cnt;
  logic               w_bit_tick;
  logic               w_ready;
  logic               w_accept;

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (r_state != SHIFT),
    .bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Abort overrides everything, including forcing tx_ready low so no word is taken.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    load_enable  = 1'b0;
    shift_enable = 1'b0;
    word_done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
      end
      LOAD: begin
        load_enable  = 1'b1;
        w_next_state = SHIFT;
      end
      SHIFT: begin
        if (w_bit_tick) begin
          if (r_bit_cnt != c_LAST_BIT) begin
            shift_enable = 1'b1;
          end else begin
            word_done    = 1'b1;
            w_ready      = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
    if (tx_bus.tx_abort) begin
      w_ready      = 1'b0;
      load_enable  = 1'b0;
      shift_enable = 1'b0;
      word_done    = 1'b0;
      w_next_state = IDLE;
    end else if (w_ready && tx_bus.tx_valid) begin
      w_next_state = LOAD;
    end
  end

  assign w_accept        = w_ready && tx_bus.tx_valid;
  assign tx_bus.tx_ready = w_ready;
  assign s_reset         = (r_state == IDLE);
  assign tx_active       = (r_state == SHIFT);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_cnt <= '0;
    end else if (r_state == LOAD) begin
      r_bit_cnt <= '0;
    end else if ((r_state == SHIFT) && w_bit_tick) begin
      r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_in <= '0;
    end else if (w_accept) begin
      parallel_in <= tx_bus.tx_data;
    end
  end

`ifdef TX_PARITY_EN
  // Parity is fed into the LSB on every shift, so it reaches the line after the data bits.
  logic r_parity;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^tx_bus.tx_data;
    end
  end

  assign serial_in = r_parity;
`else
  assign serial_in = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tx_shift_ctrl.sv
//==============================================================================
// Module : tb_tx_shift_ctrl
// Brief  : Directed bench for tx_shift_ctrl with a downstream shift register.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_tx_shift_ctrl;

`ifdef TX_PARITY_EN
  localparam int c_NB = 9;
`else
  localparam int c_NB = 8;
`endif

  logic       clk;
  logic       n_rst;
  logic       load_enable;
  logic [7:0] parallel_in;
  logic       shift_enable;
  logic       serial_in;
  logic       s_reset;
  logic       tx_active;
  logic       word_done;
  logic [7:0] r_sr;
  logic       serial_out;

  int n_checks = 0;
  int n_fail   = 0;

  tx_shift_ctrl_if #(.NUM_BITS(8)) tx_bus ();

  tx_shift_ctrl #(
    .NUM_BITS     (8),
    .CLKS_PER_BIT (4)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_bus       (tx_bus),
    .load_enable  (load_enable),
    .parallel_in  (parallel_in),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .s_reset      (s_reset),
    .tx_active    (tx_active),
    .word_done    (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream flexible shift register, MSB out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)            r_sr <= '0;
    else if (s_reset)      r_sr <= '0;
    else if (load_enable)  r_sr <= parallel_in;
    else if (shift_enable) r_sr <= {r_sr[6:0], serial_in};
  end
  assign serial_out = r_sr[7];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line bits, MSB-first in [c_NB-1:0]; p is the hand-computed even parity.
  function automatic logic [8:0] lw(input logic [7:0] w, input logic p);
`ifdef TX_PARITY_EN
    return {w, p};
`else
    return {p & 1'b0, w};
`endif
  endfunction

  task automatic start_word(input logic [7:0] w);
    @(negedge clk);
    tx_bus.tx_data  = w;
    tx_bus.tx_valid = 1'b1;
    #1;
    check_eq("accept_ready", tx_bus.tx_ready, 1'b1);
  endtask

  // Called at the accept cycle; walks the whole word relative to it.
  task automatic run_word(input logic [7:0] w, input logic [8:0] bits,
                          input bit next_valid, input logic [7:0] next_w);
    int last;
    int k;
    int ph;
    last = 4 * c_NB + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tx_bus.tx_valid = next_valid;
        if (next_valid) tx_bus.tx_data = next_w;
      end
      #1;
      k  = (c - 2) / 4;
      ph = (c - 2) % 4;
      if (c == 1) check_eq("parallel_in", parallel_in, w);
      check_eq("load_enable", load_enable, c == 1);
      check_eq("tx_active", tx_active, c >= 2);
      check_eq("word_done", word_done, c == last);
      check_eq("tx_ready", tx_bus.tx_ready, c == last);
      check_eq("shift_enable", shift_enable, (c >= 2) && (ph == 3) && (k < c_NB - 1));
      if (c >= 2) check_eq("line_bit", serial_out, bits[c_NB-1-k]);
    end
  endtask

  initial begin
    int seen;
    n_rst           = 1'b0;
    tx_bus.tx_data  = '0;
    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_abort = 1'b0;

    // Reset values
    @(negedge clk); #1;
    check_eq("rst_load", load_enable, 1'b0);
    check_eq("rst_shift", shift_enable, 1'b0);
    check_eq("rst_active", tx_active, 1'b0);
    check_eq("rst_done", word_done, 1'b0);
    check_eq("rst_pin", parallel_in, 8'h00);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk); #1;
    check_eq("rel_ready", tx_bus.tx_ready, 1'b1);
    check_eq("rel_sreset", s_reset, 1'b1);
    check_eq("rel_serial_in", serial_in, 1'b0);

    // Single word, then idle
    start_word(8'hA5);
    run_word(8'hA5, lw(8'hA5, 1'b0), 1'b0, 8'h00);
    @(negedge clk); #1;
    check_eq("a5_idle_sreset", s_reset, 1'b1);
    check_eq("a5_idle_active", tx_active, 1'b0);

    // Back-to-back with tx_valid held
    start_word(8'hFF);
    run_word(8'hFF, lw(8'hFF, 1'b0), 1'b1, 8'h00);
    run_word(8'h00, lw(8'h00, 1'b0), 1'b0, 8'h00);
    @(negedge clk); #1;
    check_eq("b2b_idle_sreset", s_reset, 1'b1);

    // Abort 10 clocks into a word
    start_word(8'h3C);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) tx_bus.tx_valid = 1'b0;
    end
    @(negedge clk);
    tx_bus.tx_abort = 1'b1;
    #1;
    check_eq("abort_ready", tx_bus.tx_ready, 1'b0);
    check_eq("abort_done", word_done, 1'b0);
    @(negedge clk);
    tx_bus.tx_abort = 1'b0;
    #1;
    check_eq("abort_sreset", s_reset, 1'b1);
    check_eq("abort_active", tx_active, 1'b0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (word_done || shift_enable) seen++;
    end
    check_eq("abort_no_done", seen, 0);
    start_word(8'h5A);
    run_word(8'h5A, lw(8'h5A, 1'b0), 1'b0, 8'h00);

    // Abort together with a valid word in IDLE drops the word
    @(negedge clk);
    tx_bus.tx_data  = 8'hC3;
    tx_bus.tx_valid = 1'b1;
    tx_bus.tx_abort = 1'b1;
    #1;
    check_eq("abort_acc_ready", tx_bus.tx_ready, 1'b0);
    @(negedge clk);
    tx_bus.tx_valid = 1'b0;
    tx_bus.tx_abort = 1'b0;
    #1;
    check_eq("abort_acc_load", load_enable, 1'b0);
    check_eq("abort_acc_sreset", s_reset, 1'b1);

    // Async reset mid-word
    start_word(8'hFF);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) tx_bus.tx_valid = 1'b0;
    end
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_active", tx_active, 1'b0);
    check_eq("mid_rst_sreset", s_reset, 1'b1);
    check_eq("mid_rst_pin", parallel_in, 8'h00);
    check_eq("mid_rst_line", serial_out, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (shift_enable || tx_active || load_enable) seen++;
    end
    check_eq("post_rst_quiet", seen, 0);
    check_eq("post_rst_ready", tx_bus.tx_ready, 1'b1);

`ifdef TX_PARITY_EN
    // Three ones -> parity 1, ninth line bit
    start_word(8'h07);
    run_word(8'h07, lw(8'h07, 1'b1), 1'b0, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
